// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type, S-box and GF(2^8) helpers.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } aes_state_e;

    // Indexed by round number; entries past round 10 are never selected.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROWS[x[7:4]];
        return row[127 - 8 * int'(x[3:0]) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit rpc_legal(input int n);
        return (n == 1) || (n == 2) || (n == 5) || (n == 10);
    endfunction

endpackage

// File: rtl/addroundkey.sv
// AES AddRoundKey.
module addroundkey (
    input  logic [127:0] d_i,
    input  logic [127:0] k_i,
    output logic [127:0] q_o
);

    assign q_o = d_i ^ k_i;

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: previous round key to next round key.
module aes_key_step (
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_o
);

    logic [31:0] rot, sub, t;
    logic [31:0] w0, w1, w2, w3;

    assign rot = {key_i[23:0], key_i[31:24]};

    subbytes #(.NB(4)) u_sub (
        .d_i (rot),
        .q_o (sub)
    );

    assign t  = sub ^ {rcon_i, 24'h0};
    assign w0 = key_i[127:96] ^ t;
    assign w1 = key_i[95:64] ^ w0;
    assign w2 = key_i[63:32] ^ w1;
    assign w3 = key_i[31:0] ^ w2;

    assign key_o = {w0, w1, w2, w3};

endmodule

// File: rtl/mixcolumns.sv
// AES MixColumns over the four 32-bit columns.
module mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] d_i,
    output logic [127:0] q_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = d_i[127-32*c -: 32];
        assign q_o[127-32*c -: 32] = {
            xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
        };
    end

endmodule

// File: rtl/shiftrows.sv
// AES ShiftRows; byte 0 is the MSB, bytes are column-major.
module shiftrows (
    input  logic [127:0] d_i,
    output logic [127:0] q_o
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign q_o[127-8*(4*c+r) -: 8] =
                d_i[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

endmodule

// File: rtl/subbytes.sv
// Byte-wise AES S-box substitution over NB bytes.
module subbytes
    import aes_pkg::*;
#(
    parameter int NB = 16
) (
    input  logic [8*NB-1:0] d_i,
    output logic [8*NB-1:0] q_o
);

    for (genvar b = 0; b < NB; b++) begin : g_byte
        assign q_o[8*b +: 8] = sbox(d_i[8*b +: 8]);
    end

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock.
// Define AES_ROUND_TAP_EN to expose the per-cycle round tap outputs.
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int NR               = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   pt_in,
    input  logic [127:0]   key_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   ct_out,
    output logic           busy
`ifdef AES_ROUND_TAP_EN
    ,
    output logic           tap_valid,
    output logic [3:0]     tap_round,
    output logic [127:0]   tap_state
`endif
);

    localparam int RPC = ROUNDS_PER_CYCLE;

    if (!rpc_legal(RPC)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end
    if (NR != AES_NR) begin : g_bad_nr
        $error("NR must be 10 for AES-128");
    end

    aes_state_e state_q, state_d;
    logic [3:0]           round_q, round_d;
    logic [AES_BLK_W-1:0] st_q, st_d;
    logic [AES_BLK_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] ct_q, ct_d;

    logic [AES_BLK_W-1:0] st_c  [RPC+1];
    logic [AES_BLK_W-1:0] key_c [RPC+1];
    logic                 last, load;

    assign st_c[0]  = st_q;
    assign key_c[0] = key_q;

    for (genvar i = 0; i < RPC; i++) begin : g_rnd
        logic [3:0]   r;
        logic [127:0] sb, sr, mc;

        assign r = round_q + 4'(i);

        aes_key_step u_ks (
            .key_i  (key_c[i]),
            .rcon_i (RCON[r]),
            .key_o  (key_c[i+1])
        );
        subbytes u_sb (
            .d_i (st_c[i]),
            .q_o (sb)
        );
        shiftrows u_sr (
            .d_i (sb),
            .q_o (sr)
        );
        mixcolumns u_mc (
            .d_i (sr),
            .q_o (mc)
        );
        // Final round has no MixColumns.
        addroundkey u_ark (
            .d_i ((r == 4'(AES_NR)) ? sr : mc),
            .k_i (key_c[i+1]),
            .q_o (st_c[i+1])
        );
    end

    assign last      = (round_q + 4'(RPC - 1)) == 4'(AES_NR);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign load      = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign ct_out    = ct_q;

`ifdef AES_ROUND_TAP_EN
    assign tap_valid = busy;
    assign tap_round = busy ? round_q + 4'(RPC - 1) : 4'd0;
    assign tap_state = busy ? st_c[RPC] : '0;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        st_d    = st_q;
        key_d   = key_q;
        ct_d    = ct_q;
        unique case (state_q)
            IDLE: ;
            RUN: begin
                st_d    = st_c[RPC];
                key_d   = key_c[RPC];
                round_d = round_q + 4'(RPC);
                if (last) begin
                    ct_d    = st_c[RPC];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Accept from IDLE, or from DONE in the same cycle the result leaves.
        if (load) begin
            st_d    = pt_in ^ key_in;
            key_d   = key_in;
            round_d = 4'd1;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            st_q    <= '0;
            key_q   <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            st_q    <= st_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
        end
    end

endmodule
